// File: rtl/vn_pair_corrector.sv
// vn_pair_corrector
//   Requests one M_WIDTH-bit sample at a time from the upstream random-sample
//   stage, runs its bits LSB-first through a von Neumann pair corrector, and
//   packs the unbiased bits into OUT_WIDTH-bit words with a valid/ready output.
//   Discarded pairs (00/11) are counted in a saturating counter.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       keep requesting samples while high
//   sample_in    upstream sample, captured on a sample_done rising edge in REQ
//   sample_done  upstream completion level
//   sample_req   start request to upstream
//   count_out    sample index sent with the request
//   out_data     packed word, bit 0 = first emitted bit
//   out_valid    out_data valid, held until out_ready
//   out_ready    downstream accept
//   disc_count   saturating count of discarded pairs
module vn_pair_corrector #(
  parameter int M_WIDTH    = 3,
  parameter int OUT_WIDTH  = 8,
  parameter int DISC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [M_WIDTH-1:0]    sample_in,
  input  logic                  sample_done,
  output logic                  sample_req,
  output logic [M_WIDTH-1:0]    count_out,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DISC_WIDTH-1:0] disc_count
);

  // The bit index must also be able to hold M_WIDTH: that value marks a
  // sample whose last bit was consumed while a word was waiting in OUT.
  localparam int IDX_W  = $clog2(M_WIDTH + 1);
  localparam int FILL_W = $clog2(OUT_WIDTH);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(M_WIDTH - 1);
  localparam logic [IDX_W-1:0]  END_IDX   = IDX_W'(M_WIDTH);
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(OUT_WIDTH - 1);
  localparam logic [OUT_WIDTH-1:0] ONE_HOT0 = {{(OUT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, REQ, PROC, OUT} state_t;

  state_t                state_reg, state_next;
  logic                  req_reg, req_next;
  logic [M_WIDTH-1:0]    count_reg, count_next;
  logic [M_WIDTH-1:0]    sample_reg, sample_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic                  pend_valid_reg, pend_valid_next;
  logic                  pend_bit_reg, pend_bit_next;
  logic [OUT_WIDTH-1:0]  acc_reg, acc_next;
  logic [FILL_W-1:0]     fill_reg, fill_next;
  logic [OUT_WIDTH-1:0]  data_reg, data_next;
  logic                  valid_reg, valid_next;
  logic [DISC_WIDTH-1:0] disc_reg, disc_next;
  logic                  done_prev_reg, done_prev_next;

  logic [M_WIDTH-1:0]    sample_shifted;
  logic                  cur_bit;
  logic [OUT_WIDTH-1:0]  acc_with_bit;
  logic                  word_done;

  // Current bit of the held sample, selected by shifting so the index width
  // never has to match the sample width exactly.
  assign sample_shifted = sample_reg >> idx_reg;
  assign cur_bit        = sample_shifted[0];

  // Accumulator with the pending bit written at the fill position. For an
  // unequal pair the emitted value is always the first (pending) bit.
  assign acc_with_bit = (acc_reg & ~(ONE_HOT0 << fill_reg))
                      | (OUT_WIDTH'(pend_bit_reg) << fill_reg);

  always_comb begin
    state_next      = state_reg;
    req_next        = req_reg;
    count_next      = count_reg;
    sample_next     = sample_reg;
    idx_next        = idx_reg;
    pend_valid_next = pend_valid_reg;
    pend_bit_next   = pend_bit_reg;
    acc_next        = acc_reg;
    fill_next       = fill_reg;
    data_next       = data_reg;
    valid_next      = valid_reg;
    disc_next       = disc_reg;
    done_prev_next  = sample_done;
    word_done       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = REQ;
          req_next   = 1'b1;
        end
      end

      REQ: begin
        if (sample_done && !done_prev_reg) begin
          sample_next = sample_in;
          req_next    = 1'b0;
          count_next  = count_reg + M_WIDTH'(1);
          idx_next    = '0;
          state_next  = PROC;
        end
      end

      PROC: begin
        idx_next = idx_reg + IDX_W'(1);
        if (!pend_valid_reg) begin
          pend_valid_next = 1'b1;
          pend_bit_next   = cur_bit;
        end else begin
          pend_valid_next = 1'b0;
          if (pend_bit_reg != cur_bit) begin
            acc_next = acc_with_bit;
            if (fill_reg == LAST_FILL) begin
              fill_next  = '0;
              data_next  = acc_with_bit;
              valid_next = 1'b1;
              word_done  = 1'b1;
            end else begin
              fill_next = fill_reg + FILL_W'(1);
            end
          end else if (disc_reg != '1) begin
            disc_next = disc_reg + DISC_WIDTH'(1);
          end
        end

        // A completed word takes priority over the end-of-sample decision;
        // OUT revisits that decision once the word is accepted.
        if (word_done) begin
          state_next = OUT;
        end else if (idx_reg == LAST_IDX) begin
          state_next = enable ? REQ : IDLE;
          req_next   = enable;
        end
      end

      OUT: begin
        if (out_ready) begin
          valid_next = 1'b0;
          if (idx_reg == END_IDX) begin
            state_next = enable ? REQ : IDLE;
            req_next   = enable;
          end else begin
            state_next = PROC;
          end
        end
      end

      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      req_reg        <= 1'b0;
      count_reg      <= '0;
      sample_reg     <= '0;
      idx_reg        <= '0;
      pend_valid_reg <= 1'b0;
      pend_bit_reg   <= 1'b0;
      acc_reg        <= '0;
      fill_reg       <= '0;
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      disc_reg       <= '0;
      done_prev_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      req_reg        <= req_next;
      count_reg      <= count_next;
      sample_reg     <= sample_next;
      idx_reg        <= idx_next;
      pend_valid_reg <= pend_valid_next;
      pend_bit_reg   <= pend_bit_next;
      acc_reg        <= acc_next;
      fill_reg       <= fill_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      disc_reg       <= disc_next;
      done_prev_reg  <= done_prev_next;
    end
  end

  assign sample_req = req_reg;
  assign count_out  = count_reg;
  assign out_data   = data_reg;
  assign out_valid  = valid_reg;
  assign disc_count = disc_reg;

endmodule

// File: tb/tb_vn_pair_corrector.sv
// tb_vn_pair_corrector
//   Bench for vn_pair_corrector with M_WIDTH=3, OUT_WIDTH=4, DISC_WIDTH=4.
//   Table-driven four-sample vectors, hand-written multi-cycle sequences, and
//   a randomized run checked against a bit-stream reference model.
module tb_vn_pair_corrector;

  localparam int MW   = 3;
  localparam int OW   = 4;
  localparam int DW   = 4;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [MW-1:0] sample_in = '0;
  logic          sample_done = 1'b0;
  logic          out_ready = 1'b0;
  logic          sample_req;
  logic [MW-1:0] count_out;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic [DW-1:0] disc_count;

  int total = 0;
  int bad   = 0;

  // Words accepted by the downstream side, and cycles with out_valid high.
  logic [OW-1:0] got_words[$];
  int            valid_cycles = 0;

  // Reference model state: raw bit stream, emitted bits, expected words.
  bit            raw_bits[$];
  bit            emit_bits[$];
  logic [OW-1:0] exp_words[$];
  int            m_disc = 0;

  typedef struct {
    logic [MW-1:0] s0, s1, s2, s3;
    int            n_words;
    logic [OW-1:0] word;
    logic [DW-1:0] disc;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  vn_pair_corrector #(
    .M_WIDTH   (MW),
    .OUT_WIDTH (OW),
    .DISC_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sample_in  (sample_in),
    .sample_done(sample_done),
    .sample_req (sample_req),
    .count_out  (count_out),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .disc_count (disc_count)
  );

  // Inputs change just after posedge, so at negedge they are stable and a
  // handshake seen here is exactly the one taken at the following posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      valid_cycles++;
      if (out_ready) got_words.push_back(out_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    sample_done = 1'b0;
    out_ready   = 1'b0;
    sample_in   = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    got_words.delete();
    valid_cycles = 0;
  endtask

  task automatic wait_req(input int limit);
    int n;
    n = 0;
    while (!sample_req && n < limit) begin
      step();
      n++;
    end
    check("req_wait", sample_req, 1);
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!out_valid && n < limit) begin
      step();
      n++;
    end
    check("valid_wait", out_valid, 1);
  endtask

  // Present one sample: raise sample_done while a request is pending, keep
  // it high for 'hold' cycles, then drop it.
  task automatic feed(input logic [MW-1:0] v, input int hold);
    wait_req(60);
    sample_in   = v;
    sample_done = 1'b1;
    step();
    for (int i = 1; i < hold; i++) step();
    sample_done = 1'b0;
  endtask

  // Append a sample's bits LSB-first to the stream and consume whole pairs.
  task automatic model_push(input logic [MW-1:0] v);
    bit a, b;
    logic [OW-1:0] w;
    for (int i = 0; i < MW; i++) raw_bits.push_back(v[i]);
    while (raw_bits.size() >= 2) begin
      a = raw_bits.pop_front();
      b = raw_bits.pop_front();
      if (a != b) begin
        emit_bits.push_back(a);
        if (emit_bits.size() == OW) begin
          w = '0;
          for (int j = 0; j < OW; j++) w[j] = emit_bits[j];
          exp_words.push_back(w);
          emit_bits.delete();
        end
      end else if (m_disc < DMAX) begin
        m_disc++;
      end
    end
  endtask

  initial begin
    logic [MW-1:0] v;
    logic [MW-1:0] exp_idx;
    int            up_phase, up_delay, up_hold;
    bit            drain;
    int            n_cmp;

    vecs[0] = '{3'b110, 3'b010, 3'b111, 3'b000, 1, 4'b1110, 4'd2};
    vecs[1] = '{3'b111, 3'b111, 3'b111, 3'b111, 0, 4'b0000, 4'd6};
    vecs[2] = '{3'b010, 3'b101, 3'b010, 3'b101, 1, 4'b0000, 4'd0};
    vecs[3] = '{3'b001, 3'b000, 3'b001, 3'b000, 0, 4'b0000, 4'd4};
    vecs[4] = '{3'b101, 3'b101, 3'b101, 3'b101, 1, 4'b0101, 4'd2};
    vecs[5] = '{3'b011, 3'b100, 3'b011, 3'b100, 0, 4'b0000, 4'd4};

    // Reset held with random inputs and enable high.
    rst_n  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_in   = MW'($urandom);
      sample_done = 1'($urandom_range(0, 1));
      out_ready   = 1'($urandom_range(0, 1));
      step();
      check("rst_req",   sample_req, 0);
      check("rst_count", count_out, 0);
      check("rst_data",  out_data, 0);
      check("rst_valid", out_valid, 0);
      check("rst_disc",  disc_count, 0);
    end
    $display("reset: outputs checked for 5 cycles");

    // Table of four-sample runs from reset.
    for (int k = 0; k < 6; k++) begin
      do_reset();
      enable    = 1'b1;
      out_ready = 1'b1;
      feed(vecs[k].s0, 2);
      feed(vecs[k].s1, 2);
      feed(vecs[k].s2, 2);
      feed(vecs[k].s3, 2);
      wait_req(60);
      check("vec_count",  count_out, 4);
      check("vec_nwords", got_words.size(), vecs[k].n_words);
      if (vecs[k].n_words > 0 && got_words.size() > 0)
        check("vec_word", got_words[0], vecs[k].word);
      check("vec_disc", disc_count, vecs[k].disc);
      $display("vec %0d: words=%0d disc=%0d count=%0d", k, got_words.size(), disc_count, count_out);
    end

    // Backpressure: word completes on bit 0 of the fourth sample.
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b0;
    feed(3'b110, 2);
    feed(3'b010, 2);
    feed(3'b111, 2);
    feed(3'b000, 2);
    wait_valid(20);
    check("bp_word", out_data, 4'b1110);
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_data",  out_data, 4'b1110);
      check("bp_req",   sample_req, 0);
      check("bp_disc",  disc_count, 1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_drop", out_valid, 0);
    step();
    check("bp_disc1", disc_count, 1);
    check("bp_req1",  sample_req, 0);
    step();
    check("bp_disc2", disc_count, 2);
    check("bp_req2",  sample_req, 1);
    check("bp_count", count_out, 4);
    $display("backpressure: word=%0h disc=%0d", got_words.size() > 0 ? got_words[0] : 4'h0, disc_count);

    // sample_done held high well past the end of the sample.
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    wait_req(10);
    sample_in   = 3'b101;
    sample_done = 1'b1;
    step();
    check("lvl_req0",   sample_req, 0);
    check("lvl_count0", count_out, 1);
    for (int i = 0; i < 19; i++) begin
      step();
      check("lvl_count", count_out, 1);
      check("lvl_req",   sample_req, (i >= 2) ? 1 : 0);
    end
    sample_done = 1'b0;
    step();
    sample_in   = 3'b010;
    sample_done = 1'b1;
    step();
    check("lvl_recap", count_out, 2);
    check("lvl_req2",  sample_req, 0);
    sample_done = 1'b0;
    $display("level done: count=%0d", count_out);

    // Enable dropped while a sample is being processed.
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    feed(3'b110, 1);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("en_req", sample_req, 0);
    end
    check("en_count", count_out, 1);
    enable = 1'b1;
    step();
    check("en_req_again", sample_req, 1);
    check("en_count2",    count_out, 1);
    $display("enable drop: count=%0d", count_out);

    // Saturation of the discard counter.
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) feed(3'b111, 2);
    wait_req(60);
    check("sat_mid", disc_count, 9);
    for (int i = 0; i < 6; i++) feed(3'b111, 2);
    wait_req(60);
    check("sat_full",  disc_count, 4'hF);
    check("sat_valid", valid_cycles, 0);
    $display("saturation: disc=%0d", disc_count);

    // Asynchronous reset in the middle of a sample, pending bit discarded.
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    feed(3'b110, 1);
    step();
    rst_n = 1'b0;
    #1;
    check("arst_count", count_out, 0);
    check("arst_req",   sample_req, 0);
    step();
    rst_n = 1'b1;
    feed(3'b001, 1);
    wait_req(60);
    check("arst_disc",  disc_count, 0);
    check("arst_count2", count_out, 1);
    $display("async reset: disc=%0d count=%0d", disc_count, count_out);

    // Randomized run against the bit-stream model.
    do_reset();
    exp_words.delete();
    raw_bits.delete();
    emit_bits.delete();
    m_disc   = 0;
    exp_idx  = '0;
    up_phase = 0;
    up_delay = 0;
    up_hold  = 0;
    for (int cyc = 0; cyc < 3200; cyc++) begin
      drain = (cyc >= 3000);
      if (up_phase == 0) begin
        if (sample_req && up_delay == 0) begin
          v = MW'($urandom);
          check("cap_idx", count_out, exp_idx);
          exp_idx = exp_idx + MW'(1);
          model_push(v);
          sample_in   = v;
          sample_done = 1'b1;
          up_hold     = $urandom_range(0, 4);
          up_phase    = 1;
        end else begin
          if (sample_req && up_delay > 0) up_delay--;
          sample_in = MW'($urandom);
        end
      end else begin
        if (up_hold == 0) begin
          sample_done = 1'b0;
          up_phase    = 0;
          up_delay    = $urandom_range(0, 3);
        end else begin
          up_hold--;
        end
      end
      enable    = drain ? 1'b0 : ($urandom_range(0, 7) != 0);
      out_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (out_valid) check("req_in_out", sample_req, 0);
      step();
    end
    check("rnd_idle_req",   sample_req, 0);
    check("rnd_idle_valid", out_valid, 0);
    check("rnd_nwords", got_words.size(), exp_words.size());
    n_cmp = (got_words.size() < exp_words.size()) ? got_words.size() : exp_words.size();
    for (int i = 0; i < n_cmp; i++) check("rnd_word", got_words[i], exp_words[i]);
    check("rnd_disc", disc_count, m_disc);
    $display("random: samples=%0d words=%0d disc=%0d", int'(exp_idx), got_words.size(), disc_count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vn_pair_corrector.md
# vn_pair_corrector

Downstream consumer of the LFSR/upcounter random-sample stage. It requests one M_WIDTH-bit sample at a time from the upstream stage and serialises each sample LSB-first through a von Neumann pair corrector. Unbiased output bits are packed into OUT_WIDTH-bit words, which are handed on with a valid/ready handshake. It also drives the upstream sample index (`count`) and start request, and keeps a saturating count of discarded pairs for bias monitoring.

## Interface
- M_WIDTH, 3, width of each upstream sample and of the sample index
- OUT_WIDTH, 8, bits per packed output word (≥2)
- DISC_WIDTH, 16, width of the discarded-pair counter
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level; while high the block keeps requesting samples
- sample_in  in  M_WIDTH  upstream random sample, stable while sample_done is high
- sample_done  in  1  upstream completion level; a rising edge marks sample_in valid
- sample_req  out  1  start request to upstream (drives its start_shift)
- count_out  out  M_WIDTH  sample index sent upstream with the request
- out_data  out  OUT_WIDTH  packed corrected word, bit 0 = first emitted bit
- out_valid  out  1  out_data valid, held until accepted
- out_ready  in  1  downstream accept
- disc_count  out  DISC_WIDTH  saturating count of discarded (00/11) pairs

## Operation
- Reset values: sample_req=0, count_out=0, out_data=0, out_valid=0, disc_count=0. Internally the FSM is in IDLE, the pending-bit flag is cleared, the accumulator fill is 0, and the sample_done edge register is 0.
- FSM states: IDLE, REQ, PROC, OUT.
- IDLE: if enable=1, go to REQ and assert sample_req.
- REQ: sample_req=1 and count_out are held. A sample_done rising edge (registered previous value 0, current value 1) does three things: sample_in is latched, sample_req drops, and the FSM goes to PROC. The index updates as count_out <= count_out+1, wrapping modulo 2^M_WIDTH.
- PROC: one bit per cycle, index 0 to M_WIDTH-1.
  - If no bit is pending, the bit becomes the pending bit.
  - If a bit is pending, the block evaluates the pair (pending, bit). On 01 it emits 0. On 10 it emits 1. On 00 or 11 it emits nothing and increments disc_count, saturating at all-ones. The pending flag then clears.
  - An emitted bit is written to accumulator position fill, and fill increments.
  - The pending bit persists across sample boundaries, so an odd M_WIDTH pairs the last bit of one sample with the first bit of the next.
- When fill reaches OUT_WIDTH, the FSM goes to OUT. out_data is loaded with the accumulator, out_valid=1, and fill resets to 0. Processing stalls at the next unprocessed bit index.
- OUT: out_valid and out_data are held stable until out_ready=1. In the accept cycle out_valid drops and the FSM resumes PROC at the stalled bit.
- After the last bit of a sample:
  - enable=1: go to REQ.
  - enable=0: go to IDLE.
  - The accumulator and the pending bit are retained in both cases.
- Deasserting enable never aborts a sample or a pending word. It only suppresses the next request.
- sample_done edges outside REQ are ignored. The edge register still tracks the input, so a level that stays high never retriggers.

## Timing
- Request to capture: sample_req is high from the cycle after entry to REQ until the cycle after the registered rising edge of sample_done.
- Capture to first bit: PROC evaluates bit 0 in the cycle after capture. A sample without a full word takes exactly M_WIDTH cycles in PROC.
- Word emission: out_valid rises one cycle after the filling bit is processed.
- out_ready asserted in the same cycle out_valid rises is accepted that cycle.
- Simultaneous fill-complete and last-bit-of-sample: go to OUT first, then to REQ or IDLE after acceptance.
- disc_count never wraps. Once saturated it holds until reset.
- Asynchronous reset at any point, including mid-PROC or mid-OUT, clears all state immediately. The partial word and the pending bit are lost.

## Test plan
- Reset: hold rst_n=0 with random inputs. Required: every output at its reset value, and sample_req stays 0 while rst_n=0 even if enable=1.
- Packing and cross-sample pending (M_WIDTH=3, OUT_WIDTH=4): feed samples 3'b110, 3'b010, 3'b111, 3'b000. Required: exactly one word out_data=4'b1110, disc_count=2 after the last sample, and count_out=4 when the fifth request is issued.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: out_data is stable, no further bits are processed, and sample_req is not asserted. Then pulse out_ready for one cycle. Required: out_valid drops the next cycle and processing resumes at the stalled bit.
- Level sample_done: hold sample_done high for 20 cycles. Required: exactly one capture, and no new request until the sample completes.
- Enable drop mid-sample: deassert enable during PROC. Required: the sample finishes, the FSM returns to IDLE, and sample_req=0. Re-enabling issues the next count_out value.
- Saturation (DISC_WIDTH=4): feed 3'b111 repeatedly. Required: disc_count reaches 4'hF and holds, with out_valid never asserted.
